sha256_msg_feeder: RTL and testbench
====================================

Name: sha256_msg_feeder

Overview:
- Front end for the SHA256 core. Accepts a byte message as a 32-bit word stream.
- Performs FIPS 180-4 padding and splits the padded message into one or two 512-bit blocks.
- Drives the core's start/msg/blk_type inputs, tracks blk_done per block, and returns the final digest with a valid pulse.
- Sits between the block-header/merkle assembly logic and the SHA256 core.

Parameters:
- MAX_BYTES, 119, largest accepted message length in bytes (two-block limit). Fixed by the core's two-block chaining; not to be raised.
- TIMEOUT_CYCLES, 1023, cycles allowed between launch/swap and the next blk_done rise before err.
- MULTI_TYPE, 2'd2, blk_type driven for two-block messages (1 = MERKLE_LEAF, 2 = HEADER).

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  feeder accepts a word this cycle
- in_word  in  32  message word, big-endian; first byte in [31:24]
- in_last  in  1  final word of message
- in_bytes  in  2  valid bytes in the final word; 0 means 4; ignored unless in_last
- blk_start  out  1  one-cycle pulse to core start
- blk_msg  out  512  block to core; word 0 in [511:480]
- blk_type  out  2  0 = single block, else MULTI_TYPE
- blk_done  in  1  core block-done level
- core_hash  in  256  core digest
- out_hash  out  256  captured digest
- out_valid  out  1  one-cycle pulse with out_hash
- busy  out  1  high from first accepted word until out_valid or err
- err  out  1  one-cycle pulse on overflow or timeout

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset (state IDLE): in_ready=1, blk_start=0, blk_msg=0, blk_type=0, out_hash=0, out_valid=0, busy=0, err=0; word counter, timer and done-edge register cleared. Reset mid-operation abandons the message; the core must also be reset by the system.
- Buffer: 32 x 32-bit words (two blocks), word index wc is 5 bits. Byte length L = 4*(words-1) + (in_bytes==0 ? 4 : in_bytes).
- IDLE: in_ready=1. An accepted word goes to buf[0] with wc=1 and state COLLECT (or PAD if in_last).
- COLLECT: in_ready=1; each accepted word goes to buf[wc], wc++. When wc would exceed 29 without in_last, or in_last with L>MAX_BYTES:
  - go to DRAIN; in_ready stays 1 and words are discarded until in_last;
  - then pulse err and return to IDLE; no core activity.
- PAD: in_ready=0. One word per cycle, from the last data word index up to index 31:
  - bytes at or beyond L are zeroed; byte L = 0x80;
  - nblk = (L<=55) ? 1 : 2;
  - the 64-bit value L*8 occupies the last two words of block nblk;
  - then LAUNCH.
- LAUNCH: blk_msg = buf block 0; blk_type = (nblk==1) ? 0 : MULTI_TYPE; blk_start=1 for exactly one cycle; timer cleared; go to WAIT1.
- Done edge: done_rise = blk_done & ~blk_done_q. blk_done_q is registered every cycle. The level blk_done left high by a previous message must not be taken as a rise.
- WAIT1:
  - on done_rise with nblk==1: capture core_hash into out_hash the next cycle; pulse out_valid; go to IDLE;
  - on done_rise with nblk==2: load blk_msg = buf block 1 at the same clock edge that samples the rise (the core re-reads msg two edges later); clear timer; go to WAIT2.
- WAIT2: on done_rise, capture the hash, pulse out_valid, go to IDLE.
- Timeout: timer reaching TIMEOUT_CYCLES in WAIT1 or WAIT2 pulses err and returns to IDLE; out_valid is not asserted.
- blk_msg holds its value after completion until the next LAUNCH.
- busy = state != IDLE.
- Latency: last word to blk_start = (32 - last index) + 2 cycles.

Decomposition:
- Package sha256_pkg:
  - blk_type constants HASH=0, MERKLE_LEAF=1, HEADER=2;
  - feeder state enum IDLE, COLLECT, DRAIN, PAD, LAUNCH, WAIT1, WAIT2;
  - SHA256 IV constants (shared with the core).
- Sub-module sha256_pad_word (combinational): inputs word, word index, L, nblk; output padded word. Keeps the byte-mask and length-field logic out of the FSM.

Test Plan:
- Empty message (one word, in_last, in_bytes=1 with byte masked; use L=0 variant via in_bytes=0 on zero-word path disabled) -> instead send "a" (0x61000000, in_bytes=1) -> blk_msg[511:480]=0x61800000, [31:0]=0x00000008, blk_type=0, one blk_start; core digest ca978112...bb -> out_valid.
- "abc" (0x61626300, in_bytes=3) -> block word0=0x61626380, last word 0x18; out_hash=ba7816bf...15ad.
- 56-byte message (14 words, in_last, in_bytes=0) -> nblk=2, byte 56=0x80; block 1 all zero except word15=0x1C0; blk_type=2; blk_msg changes at the edge sampling the blk_done rise; a single blk_start over the whole message.
- 80-byte Bitcoin genesis header, MULTI_TYPE=2 -> first-pass digest matches the known intermediate; out_valid exactly once.
- 120-byte message -> err pulse after in_last, no blk_start, returns to IDLE; a following "abc" hashes correctly.
- Hold blk_done=0 after launch -> err after 1023 cycles; assert reset in WAIT2 -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA256 types and constants for the feeder and core
package sha256_pkg;

    localparam logic [1:0] BLK_HASH        = 2'd0;
    localparam logic [1:0] BLK_MERKLE_LEAF = 2'd1;
    localparam logic [1:0] BLK_HEADER      = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DRAIN,
        PAD,
        LAUNCH,
        WAIT1,
        WAIT2
    } feeder_state_e;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // in_bytes encodes a full final word as 0
    function automatic logic [2:0] nbytes(input logic [1:0] b);
        return (b == 2'd0) ? 3'd4 : {1'b0, b};
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// rtl/sha256_pad_word.sv - combinational FIPS 180-4 padding of one buffer word
module sha256_pad_word (
    input  logic [31:0] word_i,
    input  logic [4:0]  idx_i,
    input  logic [6:0]  len_i,
    input  logic        two_blk_i,
    output logic [31:0] word_o
);
    logic [4:0] len_idx;

    assign len_idx = two_blk_i ? 5'd31 : 5'd15;

    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (({idx_i, 2'b00} + 7'(b)) < len_i) begin
                word_o[31-8*b -: 8] = word_i[31-8*b -: 8];
            end else if (({idx_i, 2'b00} + 7'(b)) == len_i) begin
                word_o[31-8*b -: 8] = 8'h80;
            end
        end
        // 64-bit bit length; the upper word is always zero for at most 119 bytes
        if (idx_i == len_idx) begin
            word_o = {22'd0, len_i, 3'd0};
        end else if (idx_i == len_idx - 5'd1) begin
            word_o = '0;
        end
    end

endmodule

// File: rtl/sha256_msg_feeder.sv
// rtl/sha256_msg_feeder.sv - collects, pads and feeds one or two blocks to the SHA256 core
module sha256_msg_feeder
    import sha256_pkg::*;
#(
    parameter int         MAX_BYTES      = 119,
    parameter int         TIMEOUT_CYCLES = 1023,
    parameter logic [1:0] MULTI_TYPE     = 2'd2
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         blk_start,
    output logic [511:0] blk_msg,
    output logic [1:0]   blk_type,
    input  logic         blk_done,
    input  logic [255:0] core_hash,
    output logic [255:0] out_hash,
    output logic         out_valid,
    output logic         busy,
    output logic         err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    feeder_state_e  state_q, state_d;
    logic [31:0]    mem_q [32];
    logic [4:0]     wc_q, wc_d, pc_q, pc_d, widx;
    logic [6:0]     len_q, len_d;
    logic           two_q, two_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           blk_done_q, done_rise;
    logic           blk_start_q, blk_start_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;
    logic [511:0]   blk_msg_q;
    logic [1:0]     blk_type_q;
    logic [255:0]   out_hash_q;
    logic           accept, mem_we, hash_cap;
    logic [4:0]     mem_waddr;
    logic [31:0]    mem_wdata, pad_out;
    logic [7:0]     in_len;
    logic [1:0]     msg_sel;

    sha256_pad_word u_pad (
        .word_i    (mem_q[pc_q]),
        .idx_i     (pc_q),
        .len_i     (len_q),
        .two_blk_i (two_q),
        .word_o    (pad_out)
    );

    assign widx      = (state_q == IDLE) ? 5'd0 : wc_q;
    assign accept    = in_valid & in_ready;
    assign in_len    = {1'b0, widx, 2'b00} + {5'd0, nbytes(in_bytes)};
    assign done_rise = blk_done & ~blk_done_q;

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        pc_d        = pc_q;
        len_d       = len_q;
        two_d       = two_q;
        timer_d     = timer_q;
        blk_start_d = 1'b0;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = widx;
        mem_wdata   = in_word;
        msg_sel     = 2'd0;
        hash_cap    = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (in_last) begin
                        if (in_len > 8'(MAX_BYTES)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            mem_we  = 1'b1;
                            len_d   = in_len[6:0];
                            two_d   = (in_len > 8'd55);
                            pc_d    = widx;
                            state_d = PAD;
                        end
                    end else if (widx == 5'd29) begin
                        state_d = DRAIN;
                    end else begin
                        mem_we  = 1'b1;
                        wc_d    = widx + 5'd1;
                        state_d = COLLECT;
                    end
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            PAD: begin
                mem_we    = 1'b1;
                mem_waddr = pc_q;
                mem_wdata = pad_out;
                if (pc_q == 5'd31) begin
                    state_d = LAUNCH;
                end else begin
                    pc_d = pc_q + 5'd1;
                end
            end
            LAUNCH: begin
                msg_sel     = 2'd1;
                blk_start_d = 1'b1;
                timer_d     = '0;
                state_d     = WAIT1;
            end
            WAIT1, WAIT2: begin
                timer_d = timer_q + TW'(1);
                if (done_rise) begin
                    if (state_q == WAIT1 && two_q) begin
                        // core re-reads msg two edges after done, so block 1 must land now
                        msg_sel = 2'd2;
                        timer_d = '0;
                        state_d = WAIT2;
                    end else begin
                        hash_cap    = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            wc_q        <= '0;
            pc_q        <= '0;
            len_q       <= '0;
            two_q       <= 1'b0;
            timer_q     <= '0;
            blk_done_q  <= 1'b0;
            blk_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            blk_msg_q   <= '0;
            blk_type_q  <= '0;
            out_hash_q  <= '0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            two_q       <= two_d;
            timer_q     <= timer_d;
            blk_done_q  <= blk_done;
            blk_start_q <= blk_start_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            if (hash_cap) begin
                out_hash_q <= core_hash;
            end
            if (msg_sel == 2'd1) begin
                for (int i = 0; i < 16; i++) begin
                    blk_msg_q[511-32*i -: 32] <= mem_q[i];
                end
                blk_type_q <= two_q ? MULTI_TYPE : BLK_HASH;
            end else if (msg_sel == 2'd2) begin
                for (int i = 0; i < 16; i++) begin
                    blk_msg_q[511-32*i -: 32] <= mem_q[16+i];
                end
            end
        end
    end

    assign blk_start = blk_start_q;
    assign blk_msg   = blk_msg_q;
    assign blk_type  = blk_type_q;
    assign out_hash  = out_hash_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// tb/tb_sha256_msg_feeder.sv - directed self-checking bench for sha256_msg_feeder
module tb_sha256_msg_feeder;

    logic         CLK = 1'b0;
    logic         reset, in_valid, in_ready, in_last, blk_start, blk_done;
    logic         out_valid, busy, err;
    logic [31:0]  in_word;
    logic [1:0]   in_bytes, blk_type;
    logic [511:0] blk_msg;
    logic [255:0] core_hash, out_hash;

    int nvec = 0, nmis = 0;
    int n_start = 0, n_valid = 0, n_err = 0;
    int s0, v0, e0, k;
    logic [31:0] msg [40];
    logic [31:0] blk [16];

    localparam logic [255:0] H_A   = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
    localparam logic [255:0] H_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_56  = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    localparam logic [255:0] H_GEN = 256'haf42031e805ff493a07341e2f74ff58149d22ab9ba19f61343e2c86c71c5d66d;

    always #5 CLK = ~CLK;

    sha256_msg_feeder #(
        .MAX_BYTES      (119),
        .TIMEOUT_CYCLES (1023),
        .MULTI_TYPE     (2'd2)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_start (blk_start),
        .blk_msg   (blk_msg),
        .blk_type  (blk_type),
        .blk_done  (blk_done),
        .core_hash (core_hash),
        .out_hash  (out_hash),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err)
    );

    always @(posedge CLK) begin
        if (blk_start) n_start++;
        if (out_valid) n_valid++;
        if (err)       n_err++;
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pack_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = blk[i];
        return r;
    endfunction

    task automatic clr_blk();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input int n, input logic [1:0] nb);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_word  = msg[i];
            in_last  = (i == n - 1);
            in_bytes = (i == n - 1) ? nb : 2'd0;
            @(posedge CLK);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_start(input int exp_k, input string tag);
        int kk = 1;
        while (!blk_start && kk < 2000) begin
            @(negedge CLK);
            kk++;
        end
        chk(tag, kk, exp_k);
    endtask

    task automatic finish_hash(input logic [255:0] h, input string tag);
        int vv = n_valid;
        core_hash = h;
        blk_done  = 1'b1;
        @(negedge CLK);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_hash"}, out_hash, h);
        @(negedge CLK);
        chk({tag, "_idle"}, busy, 0);
        cycles(2);
        chk({tag, "_once"}, n_valid - vv, 1);
    endtask

    task automatic load_56();
        for (int i = 0; i < 14; i++) msg[i] = 32'h00010203 + 32'h04040404 * i;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_start"}, blk_start, 0);
        chk({tag, "_msg"}, blk_msg, 0);
        chk({tag, "_type"}, blk_type, 0);
        chk({tag, "_hash"}, out_hash, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_word = '0; in_last = 1'b0; in_bytes = '0;
        blk_done = 1'b0; core_hash = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge CLK);

        // "a": single block, latency 34 from the last-word cycle
        s0 = n_start;
        msg[0] = 32'h61000000;
        send(1, 2'd1);
        wait_start(34, "a_lat");
        clr_blk(); blk[0] = 32'h61800000; blk[15] = 32'h00000008;
        chk("a_blk", blk_msg, pack_blk());
        chk("a_type", blk_type, 0);
        chk("a_busy", busy, 1);
        cycles(3);
        finish_hash(H_A, "a");
        chk("a_starts", n_start - s0, 1);

        // "abc" while blk_done is still high from "a": no false rise
        msg[0] = 32'h61626300;
        send(1, 2'd3);
        wait_start(34, "abc_lat");
        clr_blk(); blk[0] = 32'h61626380; blk[15] = 32'h00000018;
        chk("abc_blk", blk_msg, pack_blk());
        v0 = n_valid;
        cycles(5);
        chk("abc_stale_busy", busy, 1);
        chk("abc_stale_valid", n_valid - v0, 0);
        blk_done = 1'b0;
        cycles(2);
        finish_hash(H_ABC, "abc");

        // 56 bytes: two blocks, block 1 only carries the length
        blk_done = 1'b0;
        s0 = n_start;
        load_56();
        send(14, 2'd0);
        wait_start(21, "m56_lat");
        clr_blk();
        for (int i = 0; i < 14; i++) blk[i] = msg[i];
        blk[14] = 32'h80000000;
        chk("m56_blk0", blk_msg, pack_blk());
        chk("m56_type", blk_type, 2);
        cycles(3);
        blk_done = 1'b1;
        @(negedge CLK);
        clr_blk(); blk[15] = 32'h000001c0;
        chk("m56_blk1", blk_msg, pack_blk());
        chk("m56_novalid", out_valid, 0);
        chk("m56_busy", busy, 1);
        cycles(2);
        blk_done = 1'b0;
        cycles(3);
        finish_hash(H_56, "m56");
        chk("m56_starts", n_start - s0, 1);

        // 80-byte genesis block header
        blk_done = 1'b0;
        msg[0] = 32'h01000000;
        for (int i = 1; i < 9; i++) msg[i] = 32'h0;
        msg[9]  = 32'h3ba3edfd; msg[10] = 32'h7a7b12b2; msg[11] = 32'h7ac72c3e; msg[12] = 32'h67768f61;
        msg[13] = 32'h7fc81bc3; msg[14] = 32'h888a5132; msg[15] = 32'h3a9fb8aa; msg[16] = 32'h4b1e5e4a;
        msg[17] = 32'h29ab5f49; msg[18] = 32'hffff001d; msg[19] = 32'h1dac2b7c;
        send(20, 2'd0);
        wait_start(15, "gen_lat");
        for (int i = 0; i < 16; i++) blk[i] = msg[i];
        chk("gen_blk0", blk_msg, pack_blk());
        chk("gen_type", blk_type, 2);
        cycles(4);
        blk_done = 1'b1;
        @(negedge CLK);
        clr_blk();
        blk[0] = 32'h4b1e5e4a; blk[1] = 32'h29ab5f49; blk[2] = 32'hffff001d; blk[3] = 32'h1dac2b7c;
        blk[4] = 32'h80000000; blk[15] = 32'h00000280;
        chk("gen_blk1", blk_msg, pack_blk());
        blk_done = 1'b0;
        cycles(4);
        finish_hash(H_GEN, "gen");

        // 120 bytes: one over the limit, rejected at in_last
        s0 = n_start; e0 = n_err;
        for (int i = 0; i < 30; i++) msg[i] = 32'ha5a5a5a5 ^ i;
        send(30, 2'd0);
        chk("ovf_err", err, 1);
        @(negedge CLK);
        chk("ovf_err_pulse", err, 0);
        chk("ovf_idle", busy, 0);
        // 136 bytes: overflows mid-stream and drains to in_last
        for (int i = 0; i < 34; i++) msg[i] = 32'h5a5a0000 + i;
        send(34, 2'd0);
        chk("drain_err", err, 1);
        cycles(10);
        chk("ovf_starts", n_start - s0, 0);
        chk("ovf_errs", n_err - e0, 2);

        // "abc" after the rejected messages
        blk_done = 1'b0;
        msg[0] = 32'h61626300;
        send(1, 2'd3);
        wait_start(34, "abc2_lat");
        clr_blk(); blk[0] = 32'h61626380; blk[15] = 32'h00000018;
        chk("abc2_blk", blk_msg, pack_blk());
        cycles(2);
        finish_hash(H_ABC, "abc2");

        // core never answers: timeout
        blk_done = 1'b0;
        v0 = n_valid;
        send(1, 2'd3);
        wait_start(34, "to_lat");
        k = 0;
        while (!err && k < 1100) begin
            @(negedge CLK);
            k++;
        end
        chk("to_window", (k >= 1023 && k <= 1025), 1);
        @(negedge CLK);
        chk("to_idle", busy, 0);
        chk("to_novalid", n_valid - v0, 0);

        // reset while waiting for the second block
        load_56();
        send(14, 2'd0);
        wait_start(21, "rst2_lat");
        cycles(2);
        blk_done = 1'b1;
        @(negedge CLK);
        chk("rst2_busy", busy, 1);
        reset = 1'b1;
        @(negedge CLK);
        check_reset_outputs("rst2");
        reset = 1'b0;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
